// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder: the master drives operands and
// consumes results, the slave (the adder) does the reverse.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, val1, val2, cin,
    input  sum, cout, ovf, out_valid
  );

  modport slave (
    input  in_valid, val1, val2, cin,
    output sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder: sum/cout/ovf captured one cycle after a
// valid operand set; out_valid tracks in_valid with one cycle of delay.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  bus
);

  logic [WIDTH-1:0] s;
  logic             carry;
  logic             c_msb;

  // carry is reused as the running ripple value; c_msb keeps the carry into the MSB
  always_comb begin
    s     = '0;
    carry = bus.cin;
    c_msb = bus.cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) c_msb = carry;
      s[i]  = bus.val1[i] ^ bus.val2[i] ^ carry;
      carry = (bus.val1[i] & bus.val2[i]) | (carry & (bus.val1[i] ^ bus.val2[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum  <= s;
        bus.cout <= carry;
        bus.ovf  <= c_msb ^ carry;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 and WIDTH=8 instances run side by side
// against an arithmetic reference model.
module tb_full_adder;

  logic clk;
  logic rst_n;

  full_adder_if #(.WIDTH(1)) b1 ();
  full_adder_if #(.WIDTH(8)) b8 ();

  full_adder #(.WIDTH(1)) u_fa1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  full_adder #(.WIDTH(8)) u_fa8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state
  longint m1_sum, m8_sum;
  bit     m1_cout, m1_ovf, m1_valid;
  bit     m8_cout, m8_ovf, m8_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Unsigned sum modulo 2^w, carry-out as bit w, overflow from the true
  // signed sum leaving the w-bit two's-complement range.
  function automatic void ref_add(input int w, input longint a, input longint b,
                                  input longint c, output longint s,
                                  output bit co, output bit ov);
    longint lim, t, sa, sb, st;
    lim = longint'(1) << w;
    t   = a + b + c;
    s   = t % lim;
    co  = (t >= lim);
    sa  = (a >= lim / 2) ? a - lim : a;
    sb  = (b >= lim / 2) ? b - lim : b;
    st  = sa + sb + c;
    ov  = (st > lim / 2 - 1) || (st < -(lim / 2));
  endfunction

  task automatic drive1(input bit v, input bit a, input bit b, input bit c);
    b1.in_valid = v; b1.val1 = a; b1.val2 = b; b1.cin = c;
  endtask

  task automatic drive8(input bit v, input logic [7:0] a, input logic [7:0] b, input bit c);
    b8.in_valid = v; b8.val1 = a; b8.val2 = b; b8.cin = c;
  endtask

  task automatic model_reset();
    m1_sum = 0; m1_cout = 0; m1_ovf = 0; m1_valid = 0;
    m8_sum = 0; m8_cout = 0; m8_ovf = 0; m8_valid = 0;
  endtask

  // Advance one clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m1_valid = b1.in_valid;
      if (b1.in_valid)
        ref_add(1, longint'(b1.val1), longint'(b1.val2), longint'(b1.cin), m1_sum, m1_cout, m1_ovf);
      m8_valid = b8.in_valid;
      if (b8.in_valid)
        ref_add(8, longint'(b8.val1), longint'(b8.val2), longint'(b8.cin), m8_sum, m8_cout, m8_ovf);
    end
    @(negedge clk);
    check("w1.sum",   64'(b1.sum),       64'(m1_sum));
    check("w1.cout",  64'(b1.cout),      64'(m1_cout));
    check("w1.ovf",   64'(b1.ovf),       64'(m1_ovf));
    check("w1.valid", 64'(b1.out_valid), 64'(m1_valid));
    check("w8.sum",   64'(b8.sum),       64'(m8_sum));
    check("w8.cout",  64'(b8.cout),      64'(m8_cout));
    check("w8.ovf",   64'(b8.ovf),       64'(m8_ovf));
    check("w8.valid", 64'(b8.out_valid), 64'(m8_valid));
  endtask

  initial begin
    logic [1:0] tt_exp [8];
    logic [2:0] k;
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // reset held with all-ones valid inputs: outputs must stay cleared
    rst_n = 1'b0;
    model_reset();
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    repeat (3) tick();
    check("rst.w1", {b1.out_valid, b1.ovf, b1.cout, 61'(b1.sum)}, 64'd0);
    check("rst.w8", {b8.out_valid, b8.ovf, b8.cout, 61'(b8.sum)}, 64'd0);
    rst_n = 1'b1;

    // WIDTH=1 truth table, each vector held several cycles
    for (int unsigned i = 0; i < 8; i++) begin
      k = 3'(i);
      drive1(1'b1, k[2], k[1], k[0]);
      tick();
      check("tt.cout_sum", 64'({b1.cout, b1.sum}), 64'(tt_exp[i]));
      check("tt.ovf", 64'(b1.ovf), 64'(k[0] ^ tt_exp[i][1]));
      tick();
      tick();
    end

    // hold: invalid cycle keeps the last result, out_valid drops
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("hold.sum",   64'(b1.sum), 64'd1);
    check("hold.cout",  64'(b1.cout), 64'd1);
    check("hold.valid", 64'(b1.out_valid), 64'd0);

    // back-to-back alternation 111 / 000
    for (int unsigned i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive1(1'b1, 1'b1, 1'b1, 1'b1);
      else            drive1(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("pipe.cout_sum", 64'({b1.cout, b1.sum}), (i % 2 == 0) ? 64'd3 : 64'd0);
      check("pipe.valid", 64'(b1.out_valid), 64'd1);
    end

    // WIDTH=8 boundary vectors
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    check("w8.ff_01", {b8.ovf, b8.cout, 54'd0, b8.sum}, {1'b0, 1'b1, 54'd0, 8'h00});
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    check("w8.7f_01", {b8.ovf, b8.cout, 54'd0, b8.sum}, {1'b1, 1'b0, 54'd0, 8'h80});
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    tick();
    check("w8.ff_ff_1", {b8.ovf, b8.cout, 54'd0, b8.sum}, {1'b0, 1'b1, 54'd0, 8'hFF});
    drive8(1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    check("w8.zero", {b8.ovf, b8.cout, 54'd0, b8.sum}, 64'd0);

    // asynchronous reset in the low phase: outputs clear before the next edge
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive8(1'b1, 8'hC3, 8'h5A, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst.w1", {b1.out_valid, b1.ovf, b1.cout, 61'(b1.sum)}, 64'd0);
    check("arst.w8", {b8.out_valid, b8.ovf, b8.cout, 61'(b8.sum)}, 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic with gaps on both widths
    for (int unsigned i = 0; i < 1000; i++) begin
      drive8($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
      drive1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
Registered single-stage adder. Sums two operands and a carry-in, producing a sum and a carry-out one clock later. Built as a ripple chain of 1-bit full-adder cells. The default WIDTH=1 gives the classic 1-bit full adder used as the base cell of the adder/subtractor family.

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands on val1/val2/cin are valid this cycle
val1  input  WIDTH  addend A, unsigned
val2  input  WIDTH  addend B, unsigned
cin  input  1  carry-in to bit 0
sum  output  WIDTH  registered sum, (val1+val2+cin) mod 2^WIDTH
cout  output  1  registered carry-out of MSB
ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB
out_valid  output  1  sum/cout/ovf hold a result produced from a valid input

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low clears sum, cout, ovf and out_valid to 0 immediately, with no clock needed.
  - Reset asserted mid-operation discards any in-flight result.
  - Release is sampled at clk edges. The first capture occurs on the first rising edge with rst_n high.
- Datapath, combinational ripple chain:
  - c[0]=cin.
  - For i in 0..WIDTH-1: s[i]=val1[i]^val2[i]^c[i], c[i+1]=(val1[i]&val2[i])|(c[i]&(val1[i]^val2[i])).
- Capture: on a rising clk edge with in_valid=1:
  - sum<=s, cout<=c[WIDTH], ovf<=c[WIDTH-1]^c[WIDTH].
  - For WIDTH=1, c[0]=cin, so ovf=cin^cout.
- Hold: on an edge with in_valid=0, sum/cout/ovf keep their previous values.
- out_valid <= in_valid every edge.
- Latency: exactly 1 cycle from input edge to output.
- Throughput: one result per cycle. Back-to-back valids are fully pipelined with no bubbles and no backpressure.
- Arithmetic is unsigned and modulo 2^WIDTH; cout is bit WIDTH of the true sum.
- Boundaries:
  - All-ones + all-ones + cin=1 gives sum=all-ones, cout=1.
  - All-zero with cin=0 gives sum=0, cout=0.
- Inputs are not registered. The bench drives them stable around the rising edge; there is no X-propagation requirement beyond standard RTL semantics.
- No latches. All state is in a single always block, reset by rst_n.

Test Plan:
- Reset: hold rst_n=0 with val1=val2=cin=1, in_valid=1 -> sum=0, cout=0, ovf=0, out_valid=0. Assert rst_n mid-stream -> outputs clear asynchronously before the next clk edge.
- WIDTH=1 exhaustive truth table: in_valid=1, apply (val1,val2,cin) in order 000,001,010,011,100,101,110,111, holding each for several cycles -> one cycle after each change, (cout,sum) = 00,01,01,10,01,10,10,11.
- Hold: apply 1,1,1 with in_valid=1, then 0,0,0 with in_valid=0 -> sum=1, cout=1 retained; out_valid falls to 0 one cycle later.
- Pipelining: WIDTH=1, alternate 111 and 000 every cycle with in_valid=1 -> outputs alternate (1,1),(0,0) exactly one cycle behind; out_valid stays 1.
- WIDTH=8: 0xFF+0x01+0 -> sum=0x00, cout=1, ovf=0. 0x7F+0x01+0 -> sum=0x80, cout=0, ovf=1. 0xFF+0xFF+1 -> sum=0xFF, cout=1, ovf=0.
- WIDTH=8 random: 1000 random valid vectors with random in_valid gaps -> each output matches the reference model {cout,sum}=val1+val2+cin delayed 1 cycle.
